// File: rtl/frame_pkg.sv
// Shared types for the head/body/tail framed byte bus: beat kinds, error codes, receiver states.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        BAD_LEN      = 2'd1,
        LEN_MISMATCH = 2'd2,
        CSUM         = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_DISCARD
    } state_t;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous payload FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module frame_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/frame_rx.sv
// Receive framer: checks HEAD length and TAIL checksum, forwards body words through frame_fifo.
// Define FRAME_RX_CSUM_EN to compare TAIL data against the XOR of the accepted body words.
module frame_rx
    import frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_kind,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int CW = $clog2(MAX_LEN + 1);

    state_t          state;
    kind_t           kind;
    logic [CW-1:0]   len;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_inc;
    logic            overrun;
    logic            done_q;
    logic            err_q;
    err_t            code_q;
`ifdef FRAME_RX_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    logic            accept;
    logic            good_len;
    logic            push;
    logic [DATA_W:0] push_word;
    logic [DATA_W:0] pop_word;
    logic            fifo_full;
    logic            fifo_empty;

    assign kind      = kind_t'(in_kind);
    assign in_ready  = (state != S_BODY) || !fifo_full;
    assign accept    = in_valid && in_ready;
    assign good_len  = (in_data != '0) && (in_data <= DATA_W'(MAX_LEN));
    assign count_inc = count + CW'(1);

    always_comb begin
        push      = 1'b0;
        push_word = {(count_inc == len), in_data};
        if (accept && state == S_BODY && kind == BODY && count < len)
            push = 1'b1;
    end

    frame_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (out_ready),
        .pop_data  (pop_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Gate the raw memory read so outputs are zero whenever nothing is queued.
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : pop_word[DATA_W-1:0];
    assign out_last   = !fifo_empty && pop_word[DATA_W];
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len     <= '0;
            count   <= '0;
            overrun <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= NONE;
`ifdef FRAME_RX_CSUM_EN
            csum    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= NONE;
            if (accept) begin
                unique case (state)
                    S_IDLE: begin
                        if (kind == HEAD) begin
                            if (good_len) begin
                                len     <= CW'(in_data);
                                count   <= '0;
                                overrun <= 1'b0;
`ifdef FRAME_RX_CSUM_EN
                                csum    <= '0;
`endif
                                state   <= S_BODY;
                            end else begin
                                err_q  <= 1'b1;
                                code_q <= BAD_LEN;
                                state  <= S_DISCARD;
                            end
                        end
                    end
                    S_BODY: begin
                        case (kind)
                            BODY: begin
                                if (count < len) begin
                                    count <= count_inc;
`ifdef FRAME_RX_CSUM_EN
                                    csum  <= csum ^ in_data;
`endif
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                            TAIL: begin
                                if (count != len || overrun) begin
                                    err_q  <= 1'b1;
                                    code_q <= LEN_MISMATCH;
                                end
`ifdef FRAME_RX_CSUM_EN
                                else if (csum != in_data) begin
                                    err_q  <= 1'b1;
                                    code_q <= CSUM;
                                end
`endif
                                else begin
                                    done_q <= 1'b1;
                                end
                                state <= S_IDLE;
                            end
                            HEAD: begin
                                // The abort pulse takes the single pulse slot; a bad new
                                // length still routes the new frame to S_DISCARD.
                                err_q  <= 1'b1;
                                code_q <= LEN_MISMATCH;
                                if (good_len) begin
                                    len     <= CW'(in_data);
                                    count   <= '0;
                                    overrun <= 1'b0;
`ifdef FRAME_RX_CSUM_EN
                                    csum    <= '0;
`endif
                                    state   <= S_BODY;
                                end else begin
                                    state <= S_DISCARD;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_DISCARD: begin
                        if (kind == TAIL)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_rx.sv
// Scoreboard bench for frame_rx: tests queue expected words and pulses, a monitor pops and compares.
module tb_frame_rx;
    import frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_kind = 2'd0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [8:0] wq[$];
    logic [3:0] pq[$];
    logic       stall_prev = 1'b0;
    logic [8:0] held = '0;

    frame_rx #(.DATA_W(8), .MAX_LEN(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_kind    (in_kind),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || {out_last, out_data} !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b word=%h, required valid=1 word=%h",
                             out_valid, {out_last, out_data}, held);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL out_word: got unexpected word %h, required none", {out_last, out_data});
                end else begin
                    logic [8:0] exp_w;
                    exp_w = wq.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        errors++;
                        $display("FAIL out_word: got last=%b data=%h, required last=%b data=%h",
                                 out_last, out_data, exp_w[8], exp_w[7:0]);
                    end
                end
            end
            if (frame_done === 1'b1 || frame_err === 1'b1) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: got unexpected done=%b err=%b code=%0d, required none",
                             frame_done, frame_err, err_code);
                end else begin
                    logic [3:0] exp_p;
                    exp_p = pq.pop_front();
                    if ({frame_done, frame_err, err_code} !== exp_p) begin
                        errors++;
                        $display("FAIL pulse: got done=%b err=%b code=%0d, required done=%b err=%b code=%0d",
                                 frame_done, frame_err, err_code, exp_p[3], exp_p[2], exp_p[1:0]);
                    end
                end
            end else if (err_code !== 2'd0) begin
                checks++;
                errors++;
                $display("FAIL err_code_idle: got %0d, required 0", err_code);
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            held = {out_last, out_data};
        end
    end

    task automatic beat(input kind_t k, input logic [7:0] d);
        int unsigned n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_kind  = k;
        in_data  = d;
        #1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_kind  = 2'd0;
    endtask

    task automatic check_drained(input string name);
        int unsigned n = 0;
        while ((wq.size() != 0 || pq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        checks++;
        if (wq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d words %0d pulses pending, required 0 0",
                     name, wq.size(), pq.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, frame_done, frame_err, err_code} !== {1'b1, 14'd0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b v=%b d=%h l=%b dn=%b er=%b c=%0d, required 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, frame_done, frame_err, err_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        wq.push_back({1'b0, 8'h11});
        wq.push_back({1'b0, 8'h22});
        wq.push_back({1'b1, 8'h33});
        pq.push_back(4'b1000);
        beat(HEAD, 8'd3);
        beat(BODY, 8'h11);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL basic_latency: got v=%b d=%h, required v=1 d=11", out_valid, out_data);
        end
        beat(BODY, 8'h22);
        beat(BODY, 8'h33);
        beat(TAIL, 8'h00);
        checks++;
        if (frame_done !== 1'b1 || frame_err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL basic_done_timing: got dn=%b er=%b c=%0d, required 1 0 0",
                     frame_done, frame_err, err_code);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got %b, required 0", frame_done);
        end
        check_drained("basic");
    endtask

    task automatic test_csum();
        wq.push_back({1'b0, 8'h11});
        wq.push_back({1'b0, 8'h22});
        wq.push_back({1'b1, 8'h33});
`ifdef FRAME_RX_CSUM_EN
        pq.push_back({2'b01, 2'd3});
`else
        pq.push_back(4'b1000);
`endif
        beat(HEAD, 8'd3);
        beat(BODY, 8'h11);
        beat(BODY, 8'h22);
        beat(BODY, 8'h33);
        beat(TAIL, 8'h01);
        check_drained("csum");
    endtask

    task automatic test_len_errors();
        wq.push_back({1'b0, 8'hA1});
        wq.push_back({1'b1, 8'hA2});
        pq.push_back({2'b01, 2'd2});
        beat(HEAD, 8'd2);
        beat(BODY, 8'hA1);
        beat(BODY, 8'hA2);
        beat(BODY, 8'hA3);
        beat(TAIL, 8'hA1 ^ 8'hA2);
        check_drained("overrun");

        wq.push_back({1'b0, 8'h07});
        pq.push_back({2'b01, 2'd2});
        beat(HEAD, 8'd3);
        beat(BODY, 8'h07);
        beat(TAIL, 8'h07);
        check_drained("underrun");

        pq.push_back({2'b01, 2'd1});
        beat(HEAD, 8'd0);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL badlen0_timing: got er=%b c=%0d, required 1 1", frame_err, err_code);
        end
        beat(BODY, 8'hEE);
        beat(BODY, 8'hEF);
        beat(TAIL, 8'h00);
        pq.push_back({2'b01, 2'd1});
        beat(HEAD, 8'd17);
        beat(BODY, 8'hEE);
        beat(TAIL, 8'h00);
        wq.push_back({1'b1, 8'h5A});
        pq.push_back(4'b1000);
        beat(HEAD, 8'd1);
        beat(BODY, 8'h5A);
        beat(TAIL, 8'h5A);
        check_drained("badlen");
    endtask

    task automatic test_max_len();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] w;
            w = 8'(i * 7 + 3);
            x ^= w;
            wq.push_back({(i == 15), w});
        end
        pq.push_back(4'b1000);
        beat(HEAD, 8'd16);
        for (int i = 0; i < 16; i++)
            beat(BODY, 8'(i * 7 + 3));
        beat(TAIL, x);
        check_drained("maxlen");
    endtask

    task automatic test_backpressure();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wq.push_back({(i == 7), 8'(8'h80 + i)});
            x ^= 8'(8'h80 + i);
        end
        pq.push_back(4'b1000);
        @(negedge clk);
        out_ready = 1'b0;
        beat(HEAD, 8'd8);
        for (int i = 0; i < 4; i++)
            beat(BODY, 8'(8'h80 + i));
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h80) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%h, required 0 1 80", in_ready, out_valid, out_data);
        end
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++)
            beat(BODY, 8'(8'h80 + i));
        beat(TAIL, x);
        check_drained("bp");
    endtask

    task automatic test_abort();
        wq.push_back({1'b0, 8'h01});
        wq.push_back({1'b0, 8'h02});
        pq.push_back({2'b01, 2'd2});
        wq.push_back({1'b1, 8'hAA});
        pq.push_back(4'b1000);
        beat(HEAD, 8'd4);
        beat(BODY, 8'h01);
        beat(BODY, 8'h02);
        beat(HEAD, 8'd1);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL abort_timing: got er=%b c=%0d, required 1 2", frame_err, err_code);
        end
        beat(BODY, 8'hAA);
        beat(TAIL, 8'hAA);
        check_drained("abort");
    endtask

    task automatic test_back_to_back();
        int unsigned t0;
        int unsigned t1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++)
                wq.push_back({(i == 2), 8'(8'h40 + f * 16 + i)});
            pq.push_back(4'b1000);
        end
        t0 = $time;
        for (int f = 0; f < 2; f++) begin
            beat(HEAD, 8'd3);
            for (int i = 0; i < 3; i++)
                beat(BODY, 8'(8'h40 + f * 16 + i));
            beat(TAIL, 8'(8'h40 + f * 16) ^ 8'(8'h41 + f * 16) ^ 8'(8'h42 + f * 16));
        end
        t1 = $time;
        checks++;
        if ((t1 - t0) / 10 > 11) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d cycles for 10 beats, required <= 11", (t1 - t0) / 10);
        end
        check_drained("b2b");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        out_ready = 1'b0;
        beat(HEAD, 8'd5);
        beat(BODY, 8'h61);
        beat(BODY, 8'h62);
        @(negedge clk);
        rst_n = 1'b0;
        wq.delete();
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, frame_done, frame_err, err_code} !== {1'b1, 14'd0}) begin
            errors++;
            $display("FAIL midreset_values: got rdy=%b v=%b d=%h l=%b dn=%b er=%b c=%0d, required 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, frame_done, frame_err, err_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        wq.push_back({1'b0, 8'h71});
        wq.push_back({1'b1, 8'h72});
        pq.push_back(4'b1000);
        beat(HEAD, 8'd2);
        beat(BODY, 8'h71);
        beat(BODY, 8'h72);
        beat(TAIL, 8'h71 ^ 8'h72);
        check_drained("midreset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_csum();
        test_len_errors();
        test_max_len();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
